// File: rtl/mips_multicycle_control.sv
// Main control unit for the multicycle MIPS datapath: a Moore FSM that decodes
// the IR opcode and drives every datapath enable, mux select and alu_op.
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EX   = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  state_t r_state;
  logic   w_op_legal;

  assign w_op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);
  assign state = r_state;

  // State register; reset parks the FSM in IDLE so all decoded outputs drop at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      r_state <= S_FETCH;
        S_FETCH:     r_state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEM_ADDR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            OP_ADDI:      r_state <= S_ADDI_EX;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: begin
          if (opcode == OP_LW) begin
            r_state <= S_MEM_READ;
          end else if (opcode == OP_SW) begin
            r_state <= S_MEM_WRITE;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEM_READ:  r_state <= mem_ready ? S_MEM_WB : S_MEM_READ;
        S_MEM_WB:    r_state <= S_FETCH;
        S_MEM_WRITE: r_state <= mem_ready ? S_FETCH : S_MEM_WRITE;
        S_EXECUTE:   r_state <= S_R_WB;
        S_R_WB:      r_state <= S_FETCH;
        S_BRANCH:    r_state <= S_FETCH;
        S_JUMP:      r_state <= S_FETCH;
        S_ADDI_EX:   r_state <= S_ADDI_WB;
        S_ADDI_WB:   r_state <= S_FETCH;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  // Moore output decode; only FETCH and MEM_WRITE look at mem_ready.
  always_comb begin
    alu_op        = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    i_or_d        = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~w_op_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
        alu_op = 2'b00;
      end
    endcase
  end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Main control unit for the multicycle MIPS datapath. Decodes the 6-bit instruction opcode through a Moore state machine and drives every datapath enable and mux select. It also generates the 2-bit `alu_op` consumed by `alu_control`, which expands it together with `funct`. Sits between the instruction register (opcode source) and the datapath/memory interface, with a simple `mem_ready` wait handshake on memory accesses.

## Interface
- `OP_RTYPE`, 6'b000000, R-type opcode
- `OP_LW`, 6'b100011, load word
- `OP_SW`, 6'b101011, store word
- `OP_BEQ`, 6'b000100, branch equal
- `OP_J`, 6'b000010, jump
- `OP_ADDI`, 6'b001000, add immediate
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  instruction[31:26] from the instruction register
- `mem_ready`  in  1  memory has completed the current read or write this cycle
- `alu_op`  out  2  00 add, 01 sub, 10 decode `funct` (to `alu_control`)
- `pc_write`, `pc_write_cond`, `ir_write`, `mem_read`, `mem_write`, `reg_write`  out  1 each  enables
- `i_or_d`, `mem_to_reg`, `reg_dst`, `alu_src_a`  out  1 each  mux selects
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction
- `illegal_op`  out  1  one-cycle pulse in DECODE for an unsupported opcode
- `state`  out  4  current state encoding, for debug

## Operation
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXECUTE 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EX 11, ADDI_WB 12. Codes 13–15 are unreachable and return to FETCH.
- Every output not listed for a state is 0.
- **IDLE:** all outputs 0. Goes to FETCH unconditionally.
- **FETCH:** mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0; goes to DECODE when `mem_ready`=1.
- **DECODE:** alu_src_a=0, alu_src_b=11, alu_op=00.
  - LW/SW → MEM_ADDR; R → EXECUTE; BEQ → BRANCH; J → JUMP; ADDI → ADDI_EX.
  - Any other opcode: illegal_op=1 → FETCH.
- **MEM_ADDR:** alu_src_a=1, alu_src_b=10, alu_op=00. LW → MEM_READ, SW → MEM_WRITE. The opcode is held stable by the IR.
- **MEM_READ:** mem_read=1, i_or_d=1. Waits for `mem_ready`, then → MEM_WB.
- **MEM_WB:** reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. → FETCH.
- **MEM_WRITE:** mem_write=1, i_or_d=1. Waits for `mem_ready`. instr_done = `mem_ready`. → FETCH on `mem_ready`.
- **EXECUTE:** alu_src_a=1, alu_src_b=00, alu_op=10. → R_WB.
- **R_WB:** reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. → FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. → FETCH.
- **JUMP:** pc_write=1, pc_source=10, instr_done=1. → FETCH.
- **ADDI_EX:** alu_src_a=1, alu_src_b=10, alu_op=00. → ADDI_WB.
- **ADDI_WB:** reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. → FETCH.
- `mem_ready` is ignored outside FETCH, MEM_READ and MEM_WRITE.

## Timing
- **Reset:** `rst_n` low asynchronously forces state=IDLE. All outputs read 0 immediately and stay 0 until the first rising edge after `rst_n` deasserts.
- **Reset mid-instruction:** the instruction is abandoned with no further writes. Execution restarts through IDLE then FETCH.
- **Output decode:**
  - Outputs are combinational from `state` only, except the `mem_ready` qualifications in FETCH and MEM_WRITE.
  - State changes occur on rising `clk` only.
- **Cycle counts, FETCH through final state inclusive, `mem_ready` held 1:** LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 2.
- **Wait states:** each cycle of `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. No enables pulse during wait cycles.
- **Pulse widths:** `instr_done` and `illegal_op` are never high for more than one consecutive cycle.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n`=0 mid-MEM_WB, then release.
  - Required response: `reg_write` drops to 0 without waiting for a clock edge; state=0 while in reset; state=1 one cycle after release, then 2.
- **R-type:**
  - Stimulus: opcode=000000, `mem_ready`=1.
  - Required response: state sequence 1,2,7,8,1; `alu_op`=10 only in EXECUTE; `reg_dst`=1 and `reg_write`=1 in R_WB; `instr_done` high exactly once.
- **LW with wait states:**
  - Stimulus: opcode=100011; `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEM_READ.
  - Required response: total 10 cycles; `ir_write`/`pc_write` high only on the ready FETCH cycle; `mem_to_reg`=1 in MEM_WB.
- **SW:**
  - Stimulus: opcode=101011, `mem_ready`=1.
  - Required response: sequence 1,2,3,6,1; `mem_write`=1 and `i_or_d`=1 in MEM_WRITE; `reg_write` never asserted.
- **BEQ and J back-to-back:**
  - Stimulus: opcode=000100, then opcode=000010.
  - Required response: BEQ gives `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. J gives `pc_write`=1, `pc_source`=10. 3 cycles each.
- **Illegal opcode and ADDI:**
  - Stimulus: opcode=111111, then opcode=001000.
  - Required response: `illegal_op` pulses in DECODE and the FSM returns to FETCH after 2 cycles. ADDI follows sequence 1,2,11,12 with `alu_src_b`=10 in ADDI_EX.
